// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and the hyperbolic repeat-index list for the CORDIC controller.
package cordic_pkg;
  typedef enum logic {HYPERBOLIC = 1'b0, CIRCULAR = 1'b1} system_t;
  typedef enum logic {VECTORING = 1'b0, ROTATION = 1'b1} mode_t;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} ctrl_state_t;
  localparam int REPEAT_IDX [3] = '{4, 13, 40};
  function automatic logic is_repeat(input int s);
    is_repeat = 1'b0;
    for (int i = 0; i < 3; i++) is_repeat = is_repeat | (s == REPEAT_IDX[i]);
  endfunction
endpackage

// File: rtl/cordic_shift_sched.sv
// cordic_shift_sched: step counter and per-step shift index, with hyperbolic repeat steps.
module cordic_shift_sched
  import cordic_pkg::*;
#(
  parameter int p_WIDTH   = 32,
  parameter int p_ITERS   = 15,
  parameter int p_SHIFT_W = $clog2(p_WIDTH),
  parameter int p_STEP_W  = $clog2(p_ITERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  system_t              system_i,
  output logic [p_SHIFT_W-1:0] shift_o,
  output logic [p_STEP_W-1:0]  step_o
);
  logic [p_SHIFT_W-1:0] shift_q, shift_d;
  logic [p_STEP_W-1:0]  step_q, step_d;
  logic                 rep_q, rep_d;
  always_comb begin
    shift_d = shift_q;
    step_d  = step_q;
    rep_d   = rep_q;
    if (clear_i) begin
      shift_d = system_i == CIRCULAR ? '0 : p_SHIFT_W'(1);
      step_d  = '0;
      rep_d   = 1'b0;
    end else if (advance_i) begin
      step_d  = step_q + 1'b1;
      // rep_q marks that the second issue of a repeat index is pending
      rep_d   = system_i == HYPERBOLIC && is_repeat(int'(shift_q)) && !rep_q;
      shift_d = (rep_d || shift_q == p_SHIFT_W'(p_WIDTH - 1)) ? shift_q : shift_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      step_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
    end
  end
  assign shift_o = shift_q;
  assign step_o  = step_q;
endmodule

// File: rtl/cordic_controller.sv
// cordic_controller: sequences one operation through the cordic core (load, p_ITERS steps, result).
// Optional CORDIC_PERF_CNT_EN adds perf_ops/perf_ovf result-handshake counters.
module cordic_controller
  import cordic_pkg::*;
#(
  parameter int p_WIDTH   = 32,
  parameter int p_ITERS   = 15,
  parameter int p_SHIFT_W = $clog2(p_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [p_WIDTH-1:0]             in_x,
  input  logic [p_WIDTH-1:0]             in_y,
  input  logic [p_WIDTH-1:0]             in_z,
  input  logic                           in_system,
  input  logic                           in_mode,
  output logic                           core_load,
  output logic [p_WIDTH-1:0]             core_x_init,
  output logic [p_WIDTH-1:0]             core_y_init,
  output logic [p_WIDTH-1:0]             core_z_init,
  output logic                           core_system,
  output logic                           core_mode,
  output logic                           core_enable,
  output logic [p_SHIFT_W-1:0]           core_shift,
  input  logic [p_WIDTH-1:0]             core_x,
  input  logic [p_WIDTH-1:0]             core_y,
  input  logic [p_WIDTH-1:0]             core_z,
  input  logic                           core_overflow,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [p_WIDTH-1:0]             out_x,
  output logic [p_WIDTH-1:0]             out_y,
  output logic [p_WIDTH-1:0]             out_z,
  output logic                           out_overflow,
  output logic [$clog2(p_ITERS+1)-1:0]   out_steps
`ifdef CORDIC_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_ops,
  output logic [31:0]                    perf_ovf
`endif
);
  localparam int STEP_W = $clog2(p_ITERS + 1);
  ctrl_state_t          state_q, state_d;
  logic [p_WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  system_t              sys_q, sys_d;
  mode_t                mode_q, mode_d;
  logic                 ovf_q, ovf_d;
  logic [p_SHIFT_W-1:0] shift;
  logic [STEP_W-1:0]    step;
  cordic_shift_sched #(
    .p_WIDTH  (p_WIDTH),
    .p_ITERS  (p_ITERS),
    .p_SHIFT_W(p_SHIFT_W),
    .p_STEP_W (STEP_W)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (core_load),
    .advance_i(core_enable),
    .system_i (sys_q),
    .shift_o  (shift),
    .step_o   (step)
  );
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    sys_d       = sys_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    in_ready    = 1'b0;
    core_load   = 1'b0;
    core_enable = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = in_z;
          sys_d   = system_t'(in_system);
          mode_d  = mode_t'(in_mode);
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        state_d   = ITER;
      end
      ITER: begin
        // an overflow seen here aborts before the step it would have gated
        core_enable = !core_overflow;
        ovf_d       = core_overflow;
        state_d     = (core_overflow || step == STEP_W'(p_ITERS - 1)) ? DONE : ITER;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = out_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sys_q   <= HYPERBOLIC;
      mode_q  <= VECTORING;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sys_q   <= sys_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
  assign core_x_init  = x_q;
  assign core_y_init  = y_q;
  assign core_z_init  = z_q;
  assign core_system  = sys_q;
  assign core_mode    = mode_q;
  assign core_shift   = state_q == ITER ? shift : '0;
  assign out_x        = out_valid ? core_x : '0;
  assign out_y        = out_valid ? core_y : '0;
  assign out_z        = out_valid ? core_z : '0;
  assign out_overflow = out_valid & ovf_q;
  assign out_steps    = out_valid ? step : '0;
`ifdef CORDIC_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_ovf_q <= '0;
    end else if (out_valid && out_ready) begin
      perf_ops_q <= perf_ops_q + 32'd1;
      perf_ovf_q <= perf_ovf_q + {31'd0, ovf_q};
    end
  end
  assign perf_ops = perf_ops_q;
  assign perf_ovf = perf_ovf_q;
`endif
endmodule

// File: tb/tb_cordic_controller.sv
// tb_cordic_controller: directed + random operations against a real-valued core model and reference.
module tb_cordic_controller;
  localparam int W = 32, IT = 15, SW = 5, STW = 4;
  localparam real SC = 268435456.0;
  localparam real PI = 3.14159265358979;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_system = 1'b0, in_mode = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic core_load, core_system, core_mode, core_enable, core_overflow;
  logic [W-1:0] core_x_init, core_y_init, core_z_init, core_x, core_y, core_z;
  logic [SW-1:0] core_shift;
  logic out_valid, out_ready = 1'b1, out_overflow;
  logic [W-1:0] out_x, out_y, out_z;
  logic [STW-1:0] out_steps;
`ifdef CORDIC_PERF_CNT_EN
  logic [31:0] perf_ops, perf_ovf;
`endif
  int checks = 0, errors = 0, n_ops = 0, n_ovf = 0;
  logic [W-1:0] ex_x, ex_y, ex_z, ob_x, ob_y, ob_z;
  int ex_steps, ob_steps;
  bit ex_ovf, ob_ovf;

  always #5 clk = ~clk;

  cordic_controller dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_system(in_system), .in_mode(in_mode),
    .core_load(core_load), .core_x_init(core_x_init), .core_y_init(core_y_init),
    .core_z_init(core_z_init), .core_system(core_system), .core_mode(core_mode),
    .core_enable(core_enable), .core_shift(core_shift),
    .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_overflow(core_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_overflow(out_overflow), .out_steps(out_steps)
`ifdef CORDIC_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_ovf(perf_ovf)
`endif
  );

  function automatic real fx2r(input logic [31:0] v);
    return $itor($signed(v)) / SC;
  endfunction
  function automatic logic [31:0] r2fx(input real r);
    return 32'($rtoi(r * SC));
  endfunction
  function automatic bit big(input real a, input real b);
    return a >= 4.0 || a <= -4.0 || b >= 4.0 || b <= -4.0;
  endfunction
  function automatic void cstep(inout real x, inout real y, inout real z,
                                input bit sys, input bit mode, input int sh);
    real t, sg, ang, nx;
    t   = 2.0 ** (-sh);
    sg  = mode ? (z >= 0.0 ? 1.0 : -1.0) : (x * y >= 0.0 ? -1.0 : 1.0);
    ang = sys ? $atan(t) : 0.5 * $ln((1.0 + t) / (1.0 - t));
    nx  = sys ? x - sg * y * t : x + sg * y * t;
    y   = y + sg * x * t;
    x   = nx;
    z   = z - sg * ang;
  endfunction
  // expected shift index of step i, built from the listed schedule
  function automatic int sched_at(input bit sys, input int i);
    int q[$];
    int k = 1;
    if (sys) return i > W - 1 ? W - 1 : i;
    while (q.size() <= i) begin
      q.push_back(k > W - 1 ? W - 1 : k);
      if (k == 4 || k == 13 || k == 40) q.push_back(k > W - 1 ? W - 1 : k);
      k++;
    end
    return q[i];
  endfunction

  // core model: registered state and sticky overflow, as the controller sees them
  real cx = 0.0, cy = 0.0, cz = 0.0;
  logic cov = 1'b0;
  always @(posedge clk) begin : core_model
    real a, b, c;
    a = cx; b = cy; c = cz;
    if (core_load) begin
      cx  <= fx2r(core_x_init);
      cy  <= fx2r(core_y_init);
      cz  <= fx2r(core_z_init);
      cov <= 1'b0;
    end else if (core_enable) begin
      cstep(a, b, c, core_system, core_mode, int'(core_shift));
      cx  <= a; cy <= b; cz <= c;
      cov <= cov | big(a, b);
    end
  end
  assign core_x = r2fx(cx);
  assign core_y = r2fx(cy);
  assign core_z = r2fx(cz);
  assign core_overflow = cov;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ref_run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input bit sys, input bit mode);
    real a, b, c;
    bit ov = 0;
    a = fx2r(x); b = fx2r(y); c = fx2r(z);
    ex_steps = IT; ex_ovf = 0;
    for (int k = 0; k < IT; k++) begin
      if (ov) begin ex_ovf = 1; ex_steps = k; break; end
      cstep(a, b, c, sys, mode, sched_at(sys, k));
      ov = big(a, b);
    end
    ex_x = r2fx(a); ex_y = r2fx(b); ex_z = r2fx(c);
  endtask

  task automatic accept_req(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            input bit sys, input bit mode);
    int w = 0;
    in_x = x; in_y = y; in_z = z; in_system = sys; in_mode = mode; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("accept_bound", w < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input bit sys, input bit mode, input int hold);
    int n = 1, loads = 0;
    int sh[$];
    bit load_late = 0, en_on_ovf = 0;
    ref_run(x, y, z, sys, mode);
    out_ready = (hold == 0);
    accept_req(x, y, z, sys, mode);
    while (1) begin
      if (core_load) begin loads++; if (sh.size() != 0) load_late = 1; end
      if (core_enable) sh.push_back(int'(core_shift));
      if (core_enable && core_overflow) en_on_ovf = 1;
      if (out_valid || n >= 60) break;
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 2 + ex_steps + (ex_ovf ? 1 : 0));
    chk("load_count", loads, 1);
    chk("load_before_enable", load_late, 0);
    chk("enable_on_overflow", en_on_ovf, 0);
    chk("enable_count", sh.size(), ex_steps);
    for (int i = 0; i < sh.size(); i++) chk($sformatf("shift[%0d]", i), sh[i], sched_at(sys, i));
    ob_x = out_x; ob_y = out_y; ob_z = out_z; ob_ovf = out_overflow; ob_steps = int'(out_steps);
    chk("out_x", out_x, ex_x);
    chk("out_y", out_y, ex_y);
    chk("out_z", out_z, ex_z);
    chk("out_overflow", out_overflow, ex_ovf);
    chk("out_steps", out_steps, ex_steps);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_x", out_x, ex_x);
        chk("bp_steps", out_steps, ex_steps);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_x", out_x, 0);
    n_ops++;
    n_ovf += int'(ex_ovf);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    real r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_core_enable", core_enable, 0);
    chk("rst_x_init", core_x_init, 0);
    chk("rst_shift", core_shift, 0);
    chk("rst_steps", out_steps, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of an operation
    accept_req(r2fx(0.5), r2fx(0.1), r2fx(0.3), 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_enable_before_rst", core_enable, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enable", core_enable, 0);
    chk("mid_rst_load", core_load, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
`ifdef CORDIC_PERF_CNT_EN
    chk("mid_rst_perf_ops", perf_ops, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // circular rotation of (1/K, 0) by 45 degrees
    do_op(r2fx(0.6072529), '0, r2fx(PI / 4.0), 1'b1, 1'b1, 0);
    r = fx2r(ob_x) - 0.70710678;
    chk("circ_x_acc", r < 2e-4 && r > -2e-4, 1);
    r = fx2r(ob_y) - 0.70710678;
    chk("circ_y_acc", r < 2e-4 && r > -2e-4, 1);
    r = fx2r(ob_z);
    chk("circ_z_acc", r < 2e-4 && r > -2e-4, 1);
    chk("circ_steps", ob_steps, 15);

    // hyperbolic schedule with repeats
    do_op(r2fx(1.2), r2fx(0.3), r2fx(0.5), 1'b0, 1'b1, 0);

    // overflow abort
    do_op(r2fx(3.9), r2fx(3.9), r2fx(PI / 3.0), 1'b0, 1'b1, 0);
    chk("ovf_flag", ob_ovf, 1);
    chk("ovf_steps_short", ob_steps < 15, 1);

    // backpressure, then the request held pending during DONE
    do_op(r2fx(0.4), r2fx(-0.2), r2fx(0.7), 1'b1, 1'b0, 10);
    do_op(r2fx(-0.3), r2fx(0.25), r2fx(-0.6), 1'b0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] rx, ry, rz;
      rx = r2fx(($itor($urandom_range(0, 1000)) - 500.0) / 1000.0);
      ry = r2fx(($itor($urandom_range(0, 1000)) - 500.0) / 1000.0);
      rz = r2fx(($itor($urandom_range(0, 1600)) - 800.0) / 1000.0);
      do_op(rx, ry, rz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

`ifdef CORDIC_PERF_CNT_EN
    chk("perf_ops", perf_ops, n_ops);
    chk("perf_ovf", perf_ovf, n_ovf);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_controller.md
Name: cordic_controller

Overview:
- Hardware sequencer directly upstream of the `cordic` core. It replaces the bench-side sequencer.
- Accepts one operation (x, y, z, system, mode) over a valid/ready handshake and loads it into the core.
- Steps the core through `p_ITERS` micro-rotations using the correct shift schedule, aborting early on core overflow.
- Presents the final x/y/z plus status on an output valid/ready handshake. One operation in flight at a time.

Parameters:
- `p_WIDTH`, 32, datapath width of x, y and z in the core's fixed-point and angle formats.
- `p_ITERS`, 15, number of core steps per operation, including hyperbolic repeat steps.
- `p_SHIFT_W`, `$clog2(p_WIDTH)`, width of the shift-index bus to the core.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_x`, `in_y`  in  `p_WIDTH`  initial x, y.
- `in_z`  in  `p_WIDTH`  initial angle.
- `in_system`  in  1  1 = circular, 0 = hyperbolic.
- `in_mode`  in  1  1 = rotation, 0 = vectoring.
- `core_load`  out  1  load `core_x_init`, `core_y_init`, `core_z_init` into the core this cycle.
- `core_x_init`, `core_y_init`, `core_z_init`  out  `p_WIDTH`  latched request operands.
- `core_system`, `core_mode`  out  1  latched system/mode, held stable for the whole operation.
- `core_enable`  out  1  core performs one micro-rotation this cycle.
- `core_shift`  out  `p_SHIFT_W`  shift index for the current step.
- `core_x`, `core_y`, `core_z`  in  `p_WIDTH`  core registered state.
- `core_overflow`  in  1  core registered overflow flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_x`, `out_y`, `out_z`  out  `p_WIDTH`  result.
- `out_overflow`  out  1  operation aborted on overflow.
- `out_steps`  out  `$clog2(p_ITERS+1)`  steps completed.

Behaviour:
- **Reset:** asynchronous, active-high. Forces state IDLE and step counter 0.
  - All outputs 0 except `in_ready`, which is 1.
  - Operand latches are cleared to 0.
  - A reset mid-operation discards the operation; `core_load` and `core_enable` drop immediately.
- **FSM states:** IDLE, LOAD, ITER, DONE.
  - IDLE: `in_ready`=1. On `in_valid` && `in_ready`, latch operands, system and mode → LOAD.
  - LOAD: one cycle, `core_load`=1, step counter cleared → ITER.
  - ITER: `core_enable`=1, `core_shift`=schedule(step), step increments each cycle.
  - ITER → DONE after step `p_ITERS`-1 is issued, or on the first cycle `core_overflow`=1.
    - On overflow, that cycle's `core_enable` is suppressed, `out_overflow` is set and `out_steps` = steps issued.
  - DONE: `out_valid`=1. `out_x`/`out_y`/`out_z` pass through the core state, which is stable because `core_enable`=0.
    - Outputs are held until `out_valid` && `out_ready` → IDLE. Result outputs are 0 outside DONE.
- **Latency:** accept edge at T. `core_load` is high in cycle T+1 and ITER covers T+2 … T+1+`p_ITERS`. `out_valid` rises at T+2+`p_ITERS`, so 17 cycles with the default.
- **Throughput:** with `out_ready` tied to 1, `in_ready` returns one cycle after the result handshake.
- **Shift schedule:**
  - Circular: 0, 1, …, `p_ITERS`-1.
  - Hyperbolic: starts at 1; shifts 4, 13 and 40 (k = 3k+1) are each issued twice.
  - Hyperbolic with `p_ITERS`=15 gives 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13.
  - The shift saturates at `p_WIDTH`-1.
- **Other rules:**
  - `in_valid` while not in IDLE is ignored and not lost; it is accepted when `in_ready` next rises.
  - Overflow on the final step is handled as an abort: DONE with `out_overflow`=1 and `out_steps`=`p_ITERS`-1.
  - `core_overflow` in LOAD is ignored, because the core clears it on load.

Optional Feature:
- Macro: `CORDIC_PERF_CNT_EN`.
- **Defined:** adds outputs `perf_ops` (32 bits, completed operations, wraps) and `perf_ovf` (32 bits, overflow aborts, wraps).
  - Both increment on the result handshake.
  - Both are cleared by `rst` only.
- **Undefined:** these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package `cordic_pkg`:
  - `system_t` (CIRCULAR=1, HYPERBOLIC=0) and `mode_t` (ROTATION=1, VECTORING=0).
  - `ctrl_state_t`.
  - The repeat-index constant list 4, 13, 40.
- Sub-module `cordic_shift_sched`: step counter plus system → `core_shift`, including the repeat logic. Purely sequential counter with a pending-repeat flag.

Test Plan:
- **Circular rotation:** x=0.6072529, y=0, z=45°, `p_ITERS`=15 → `out_valid` at accept+17. `out_x` ≈ `out_y` ≈ 0.7071 (±2e-4), `out_z` ≈ 0, `out_steps`=15, `out_overflow`=0.
- **Hyperbolic schedule:** any hyperbolic request → `core_shift` sequence 1,2,3,4,4,5,…,13,13 across exactly 15 `core_enable` cycles. `core_load` is high exactly once, before the first enable.
- **Overflow abort:** hyperbolic rotation with x=3.9, y=3.9, z=60° → `core_overflow` rises mid-run. `core_enable` drops the same cycle, `out_overflow`=1, `out_steps` < 15.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0. A second `in_valid` is accepted only after the result handshake.
- **Reset mid-operation:** assert `rst` at step 7 → the same cycle `core_enable`=0, `in_ready`=1 and `out_valid`=0. After `rst` deasserts, a new request completes normally.
- **Perf counters (`CORDIC_PERF_CNT_EN`):** 3 normal operations plus the overflow case → `perf_ops`=4, `perf_ovf`=1.
